// File: rtl/mem_access_seq.sv
// Memory-stage access sequencer: optional chained pointer reads, then the final load/store.
// Latency: direct access with immediate mem_resp -> strobe in cycle 1, done in cycle 2; +1 cycle per level and per wait cycle.
// Backpressure: stall holds the MEM stage until the done cycle; mem_resp acts as the per-transaction handshake.
//
// Ports: clk/rst_n (async active-low); req_* = request from the MEM stage (held stable while stall=1);
//        mem_* = single-port memory interface, mem_resp completes the current transaction;
//        stall/done/rdata_out = pipeline side; cnt_clear/access_count/stall_count = saturating perf counters.
module mem_access_seq #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int MAX_INDIRECT = 2,
  parameter int COUNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic                req_byte,
  input  logic [2:0]          req_indirect,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata_out,
  input  logic                cnt_clear,
  output logic [COUNT_W-1:0]  access_count,
  output logic [COUNT_W-1:0]  stall_count
);

  localparam int NB = DATA_W / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [2:0] MAX_LVL = 3'(MAX_INDIRECT);

  typedef enum logic [1:0] {S_IDLE, S_IND, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [2:0]          r_level;
  logic                r_write;
  logic                r_byte;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_done;
  logic [NB-1:0]       r_wmask;
  logic [COUNT_W-1:0]  r_acc_cnt;
  logic [COUNT_W-1:0]  r_stall_cnt;

  logic [2:0]          w_eff_level;
  logic [ADDR_W-1:0]   w_ptr_addr;
  logic [7:0]          w_rd_byte;
  logic                w_stall;
  logic                w_acc_inc;

  // Word accesses enable every lane; byte accesses enable only the addressed lane.
  function automatic logic [NB-1:0] lane_mask(input logic [ADDR_W-1:0] addr, input logic is_byte);
    logic [NB-1:0] m;
    if (is_byte) begin
      m = '0;
      m[addr[LW-1:0]] = 1'b1;
    end else begin
      m = '1;
    end
    return m;
  endfunction

  assign w_eff_level = (req_indirect > MAX_LVL) ? MAX_LVL : req_indirect;
  assign w_ptr_addr  = mem_rdata[ADDR_W-1:0];
  assign w_rd_byte   = mem_rdata[{r_cur_addr[LW-1:0], 3'b000} +: 8];
  assign w_stall     = req_valid && (r_state != S_DONE);
  assign w_acc_inc   = mem_resp && ((r_state == S_IND) || (r_state == S_ACCESS));

  // Request fields are captured on acceptance so the sequence can finish even if req_valid drops.
  // Strobes/mask/done are registered with the state transition, so they are pure state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_level     <= '0;
      r_write     <= 1'b0;
      r_byte      <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
      r_wmask     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cur_addr <= req_addr;
            r_level    <= w_eff_level;
            r_write    <= req_write;
            r_byte     <= req_byte;
            r_wdata    <= req_wdata;
            if (w_eff_level != 3'd0) begin
              r_state    <= S_IND;
              r_mem_read <= 1'b1;
              r_wmask    <= '0;
            end else begin
              r_state     <= S_ACCESS;
              r_mem_read  <= !req_write;
              r_mem_write <= req_write;
              r_wmask     <= lane_mask(req_addr, req_byte);
            end
          end
        end
        S_IND: begin
          if (mem_resp) begin
            r_cur_addr <= w_ptr_addr;
            r_level    <= r_level - 3'd1;
            if (r_level == 3'd1) begin
              r_state     <= S_ACCESS;
              r_mem_read  <= !r_write;
              r_mem_write <= r_write;
              r_wmask     <= lane_mask(w_ptr_addr, r_byte);
            end
          end
        end
        S_ACCESS: begin
          if (mem_resp) begin
            if (!r_write) begin
              r_rdata <= r_byte ? {{(DATA_W-8){1'b0}}, w_rd_byte} : mem_rdata;
            end
            r_state     <= S_DONE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wmask     <= '0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (cnt_clear) begin
      r_acc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_acc_inc && (r_acc_cnt != '1)) begin
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_addr     = r_cur_addr;
  assign mem_wdata    = r_byte ? {NB{r_wdata[7:0]}} : r_wdata;
  assign mem_wmask    = r_wmask;
  assign stall        = w_stall;
  assign done         = r_done;
  assign rdata_out    = r_rdata;
  assign access_count = r_acc_cnt;
  assign stall_count  = r_stall_cnt;

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised memory-stage access sequencer for the LC-3b pipeline.
- Takes one load/store request from the MEM stage and performs zero or more chained indirect pointer reads, then the final read or write.
- Handles byte-lane masking and extraction, and generates the pipeline stall.
- Keeps saturating performance counters.
- Generalises fixed single-level LDI/STI handling to configurable data width and indirection depth.

Parameters:
DATA_W, 16, memory word width in bits; multiple of 8, at least 16
ADDR_W, 16, address width in bits
MAX_INDIRECT, 2, maximum number of chained pointer reads per request (1..7)
COUNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage holds a memory request; request fields are held stable while stall=1
req_write  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte access, 0 = word access
req_indirect  in  3  number of pointer reads before the final access (0 = direct)
req_addr  in  ADDR_W  initial effective address
req_wdata  in  DATA_W  store data; byte stores use bits [7:0]
mem_resp  in  1  memory response; completes the current transaction
mem_rdata  in  DATA_W  memory read data, valid with mem_resp
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  write data
mem_wmask  out  DATA_W/8  byte write enables
stall  out  1  hold pipeline
done  out  1  one-cycle completion pulse
rdata_out  out  DATA_W  load result, valid when done=1
cnt_clear  in  1  synchronous counter clear
access_count  out  COUNT_W  completed memory transactions
stall_count  out  COUNT_W  cycles with stall=1

Behaviour:
- States: IDLE, IND, ACCESS, DONE. Reset (asynchronous, rst_n=0) forces the following immediately:
  - state=IDLE; cur_addr, level and rdata_out cleared to 0.
  - Both counters cleared to 0.
  - mem_read, mem_write and done low; mem_wmask=0.
- Reset mid-operation abandons the request without completion. The pipeline re-presents it after reset.
- IDLE:
  - If req_valid and effective level > 0, go to IND. Effective level = min(req_indirect, MAX_INDIRECT).
  - If req_valid and effective level = 0, go to ACCESS.
  - In both cases cur_addr <= req_addr and level <= effective level.
  - No memory strobe is driven in IDLE.
- IND:
  - Drive mem_read=1, mem_addr=cur_addr, mem_wmask=0.
  - On mem_resp: cur_addr <= mem_rdata[ADDR_W-1:0] and level <= level-1. If level was 1, go to ACCESS; otherwise stay in IND.
  - Pointer reads are always full-word reads.
- ACCESS:
  - Drive mem_addr=cur_addr. Drive mem_read=~req_write and mem_write=req_write.
  - On mem_resp: capture the load result into rdata_out, then go to DONE.
  - Stores leave rdata_out unchanged.
- DONE: done=1 for exactly one cycle, then go to IDLE. A new request is accepted in IDLE on the following cycle.
- Strobes are decoded from state only (Moore outputs), so they cannot glitch on mem_resp.
- mem_resp arriving in IDLE or DONE is ignored and not counted.
- stall = req_valid && state != DONE. This is combinational, so stall is high in the arrival cycle.
- Latency, direct access with mem_resp in the first strobe cycle: request in cycle 0, strobe in cycle 1, done in cycle 2. Stall is high in cycles 0 and 1.
- Each indirect level adds at least 1 cycle. Memory wait cycles add 1 cycle each.
- If req_valid drops mid-sequence, the sequence still completes and done still pulses.
- Byte lanes: lane = cur_addr[log2(DATA_W/8)-1:0].
  - Word access: mem_wmask = all ones and mem_wdata = req_wdata. Memory ignores the low address bits.
  - Byte store: mem_wmask = one-hot at lane; mem_wdata = req_wdata[7:0] replicated into every lane.
  - Byte load: rdata_out = zero-extended mem_rdata byte at lane.
  - Word load: rdata_out = mem_rdata.
- access_count increments on every mem_resp accepted in IND or ACCESS.
- stall_count increments on every cycle with stall=1.
- Both counters saturate at all ones. cnt_clear wins over a same-cycle increment.

Test Plan:
- Direct word load, req_addr=0x3000, mem_resp in first strobe cycle with rdata 0xBEEF -> mem_read in cycle 1 at 0x3000; done in cycle 2; rdata_out=0xBEEF; stall high for 2 cycles; access_count=1.
- Byte store, req_addr=0x4001, wdata=0x12AB -> mem_write with mem_wmask=2'b10 and mem_wdata=0xABAB. A byte load from 0x4001 returning 0xCD55 gives rdata_out=0x00CD.
- Two-level indirect load, req_indirect=2, addr 0x1000:
  - Memory returns 0x2000, then 0x2400, then 0x7777.
  - Required mem_addr sequence: 0x1000, 0x2000, 0x2400.
  - rdata_out=0x7777; access_count=3.
- Indirect store, req_indirect=1, memory with 3 wait cycles per access -> first read at the pointer address, then a write at the returned address; stall spans 9 cycles; done pulses once.
- req_indirect=5 with MAX_INDIRECT=2 -> exactly 2 pointer reads. Spurious mem_resp in IDLE is not counted.
- rst_n pulsed low during IND -> strobes drop immediately, counters read 0, state=IDLE; a fresh request then completes normally. With COUNT_W=4, 20 stall cycles leave stall_count=15.
